// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and occupancy-decoded level flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow_o/underflow_o outputs.
module sync_fifo #(
    parameter int AWIDTH = 2,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              re_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              one_available_o,
`ifdef FIFO_ERR_FLAGS_EN
    output logic              two_available_o,
    output logic              overflow_o,
    output logic              underflow_o
`else
    output logic              two_available_o
`endif
);

    localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] TWO   = (AWIDTH+1)'(2);

    logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];
    logic [AWIDTH-1:0] wptr, rptr;
    logic [AWIDTH:0]   count;
    logic              wr_ok, rd_ok;

    // Acceptance is judged on the pre-edge count, so a full FIFO drops the write
    // even when a read frees a slot on the same edge.
    assign wr_ok = we_i && (count != DEPTH);
    assign rd_ok = re_i && (count != '0);

    assign empty_o         = (count == '0);
    assign full_o          = (count == DEPTH);
    assign one_available_o = (count != '0);
    assign two_available_o = (count >= TWO);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= data_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            data_o <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) begin
                rptr   <= rptr + 1'b1;
                data_o <= mem[rptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (we_i && full_o)  overflow_o  <= 1'b1;
            if (re_i && empty_o) underflow_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (default depth 4, 8-bit data).
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       empty, full, one, two;
    int         errors = 0;
    int         checks = 0;
`ifdef FIFO_ERR_FLAGS_EN
    logic       ovf, unf;
`endif

    sync_fifo #(.AWIDTH(2), .DWIDTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .we_i            (we),
        .data_i          (din),
        .re_i            (re),
        .data_o          (dout),
        .empty_o         (empty),
        .full_o          (full),
        .one_available_o (one),
`ifdef FIFO_ERR_FLAGS_EN
        .two_available_o (two),
        .overflow_o      (ovf),
        .underflow_o     (unf)
`else
        .two_available_o (two)
`endif
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; outputs sampled 1 time unit after the edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        we = w; din = d; re = r;
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        checks++;
        if ({empty, full, one, two} !== 4'b1000) begin
            errors++; $display("FAIL reset_flags got=%b want=1000", {empty, full, one, two});
        end
        checks++;
        if (dout !== 8'h00) begin
            errors++; $display("FAIL reset_data got=%h want=00", dout);
        end
    endtask

    task automatic test_single;
        cyc(1'b1, 8'hAA, 1'b0);
        checks++;
        if ({empty, full, one, two} !== 4'b0010) begin
            errors++; $display("FAIL single_wr_flags got=%b want=0010", {empty, full, one, two});
        end
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (dout !== 8'hAA || {empty, full, one, two} !== 4'b1000) begin
            errors++; $display("FAIL single_rd got=%h/%b want=aa/1000", dout, {empty, full, one, two});
        end
        // read while empty must leave data_o and flags alone
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (dout !== 8'hAA || {empty, full, one, two} !== 4'b1000) begin
            errors++; $display("FAIL underflow_rd got=%h/%b want=aa/1000", dout, {empty, full, one, two});
        end
`ifdef FIFO_ERR_FLAGS_EN
        checks++;
        if (unf !== 1'b1 || ovf !== 1'b0) begin
            errors++; $display("FAIL underflow_flag got=%b%b want=01", ovf, unf);
        end
`endif
    endtask

    task automatic test_fill;
        logic [3:0] wflags [4] = '{4'b0010, 4'b0011, 4'b0011, 4'b0111};
        logic [3:0] rflags [4] = '{4'b0011, 4'b0011, 4'b0010, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'h70 + 8'(i), 1'b0);
            checks++;
            if ({empty, full, one, two} !== wflags[i]) begin
                errors++; $display("FAIL fill_wr%0d got=%b want=%b", i, {empty, full, one, two}, wflags[i]);
            end
        end
        cyc(1'b1, 8'hAB, 1'b0);
        checks++;
        if ({empty, full, one, two} !== 4'b0111) begin
            errors++; $display("FAIL overflow_wr got=%b want=0111", {empty, full, one, two});
        end
`ifdef FIFO_ERR_FLAGS_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++; $display("FAIL overflow_flag got=%b want=1", ovf);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            checks++;
            if (dout !== 8'h70 + 8'(i) || {empty, full, one, two} !== rflags[i]) begin
                errors++; $display("FAIL fill_rd%0d got=%h/%b want=%h/%b", i, dout,
                                   {empty, full, one, two}, 8'h70 + 8'(i), rflags[i]);
            end
        end
    endtask

    task automatic test_rw_empty;
        cyc(1'b1, 8'h80, 1'b1);
        checks++;
        if (dout !== 8'h73 || {empty, full, one, two} !== 4'b0010) begin
            errors++; $display("FAIL rw_empty got=%h/%b want=73/0010", dout, {empty, full, one, two});
        end
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (dout !== 8'h80 || {empty, full, one, two} !== 4'b1000) begin
            errors++; $display("FAIL rw_empty_rd got=%h/%b want=80/1000", dout, {empty, full, one, two});
        end
    endtask

    task automatic test_rw_one;
        cyc(1'b1, 8'h90, 1'b0);
        cyc(1'b1, 8'hA0, 1'b1);
        checks++;
        if (dout !== 8'h90 || {empty, full, one, two} !== 4'b0010) begin
            errors++; $display("FAIL rw_one got=%h/%b want=90/0010", dout, {empty, full, one, two});
        end
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (dout !== 8'hA0 || {empty, full, one, two} !== 4'b1000) begin
            errors++; $display("FAIL rw_one_rd got=%h/%b want=a0/1000", dout, {empty, full, one, two});
        end
    endtask

    task automatic test_rw_full;
        logic [7:0] exp_d [3] = '{8'h12, 8'h13, 8'h21};
        logic [3:0] exp_f [3] = '{4'b0011, 4'b0010, 4'b1000};
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
        checks++;
        if ({empty, full, one, two} !== 4'b0111) begin
            errors++; $display("FAIL rw_full_fill got=%b want=0111", {empty, full, one, two});
        end
        cyc(1'b1, 8'h20, 1'b1);
        checks++;
        if (dout !== 8'h10 || {empty, full, one, two} !== 4'b0011) begin
            errors++; $display("FAIL rw_full got=%h/%b want=10/0011", dout, {empty, full, one, two});
        end
        cyc(1'b1, 8'h21, 1'b1);
        checks++;
        if (dout !== 8'h11 || {empty, full, one, two} !== 4'b0011) begin
            errors++; $display("FAIL rw_three got=%h/%b want=11/0011", dout, {empty, full, one, two});
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            checks++;
            if (dout !== exp_d[i] || {empty, full, one, two} !== exp_f[i]) begin
                errors++; $display("FAIL rw_full_rd%0d got=%h/%b want=%h/%b", i, dout,
                                   {empty, full, one, two}, exp_d[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'h66, 1'b0);
        // assert reset between edges: must take effect without a clock
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({empty, full, one, two} !== 4'b1000 || dout !== 8'h00) begin
            errors++; $display("FAIL reset_mid got=%h/%b want=00/1000", dout, {empty, full, one, two});
        end
`ifdef FIFO_ERR_FLAGS_EN
        checks++;
        if (ovf !== 1'b0 || unf !== 1'b0) begin
            errors++; $display("FAIL reset_err got=%b%b want=00", ovf, unf);
        end
`endif
        @(posedge clk); #1 reset = 1'b1;
        cyc(1'b1, 8'h77, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (dout !== 8'h77 || {empty, full, one, two} !== 4'b1000) begin
            errors++; $display("FAIL post_reset got=%h/%b want=77/1000", dout, {empty, full, one, two});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_rw_empty();
        test_rw_one();
        test_rw_full();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
